// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: FSM encoding, latency
// and the ALU-control codes the decoder maps onto start/signed_div.
package div_unit_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam logic [3:0] ALU_DIV  = 4'b1010;
  localparam logic [3:0] ALU_DIVU = 4'b1011;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore, emit one quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    // Extra top bit carries the borrow of the WIDTH+1-bit subtraction.
    diff    = {1'b0, shifted} - {2'b00, dvsr_i};
    borrow  = diff[WIDTH+1];
    rem_o   = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; LO = quotient, HI = remainder.
// busy stalls the pipeline while a division is in flight.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic             b_zero, neg_a, neg_b;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  // Divide-by-zero runs on raw operands with sign flags clear, so the
  // iteration naturally yields all-ones / original dividend.
  assign b_zero = (b == '0);
  assign neg_a  = signed_div & a[WIDTH-1] & ~b_zero;
  assign neg_b  = signed_div & b[WIDTH-1] & ~b_zero;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    valid_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          state_d = BUSY;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = neg_a ? negate(a) : a;
          dvsr_d  = neg_b ? negate(b) : b;
          qneg_d  = neg_a ^ neg_b;
          rneg_d  = neg_a;
        end
      end
      BUSY: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
        end
      end
      FIX: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          quotient_d  = qneg_q ? negate(quo_q) : quo_q;
          remainder_d = rneg_q ? negate(rem_q) : rem_q;
          valid_d     = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      valid_q     <= valid_d;
    end
  end

  assign busy = ~cancel & (((state_q == IDLE) & start) | (state_q == BUSY) | (state_q == FIX));
  assign valid     = valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a negedge
// monitor pops and compares them (value and arrival cycle) whenever valid is high.
module tb_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, signed_div, cancel;
  logic [W-1:0] a, b;
  logic         busy, valid;
  logic [W-1:0] quotient, remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   t0;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .cancel     (cancel),
    .busy       (busy),
    .valid      (valid),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && valid !== 1'b0) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", {{(W-1){1'b0}}, valid}, '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("valid_cycle", W'(cyc), W'(e.cyc));
      end
    end
  end

  // Issue one division from IDLE, scramble operands after accept, check busy
  // through the whole latency and the single DONE cycle.
  task automatic run_div(input logic sd, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] eq, input logic [W-1:0] er);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; signed_div = sd; a = av; b = bv;
    @(negedge clk); chk("busy_req", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    e.q = eq; e.r = er; e.cyc = cyc + 33;
    sb.push_back(e);
    start = 1'b0; signed_div = ~sd; a = $urandom; b = $urandom;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk); chk("busy_run", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("valid_done", {31'd0, valid}, 32'd1);
  endtask

  initial begin
    exp_t e;
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst = 1'b0; start = 1'b0; signed_div = 1'b0; cancel = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_quot", quotient, '0);
    chk("rst_rem", remainder, '0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    run_div(1'b0, 32'd7,        32'd2,        32'h00000003, 32'h00000001);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div(1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
    run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_div(1'b1, 32'h12345678, 32'h0,        32'hFFFFFFFF, 32'h12345678);
    run_div(1'b0, 32'h12345678, 32'h0,        32'hFFFFFFFF, 32'h12345678);

    // start together with cancel in IDLE: nothing is accepted
    @(posedge clk); #1;
    start = 1'b1; cancel = 1'b1; signed_div = 1'b0; a = 32'd50; b = 32'd5;
    @(negedge clk); chk("busy_start_cancel", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk); chk("idle_after_cancel", {31'd0, busy}, 32'd0);

    // cancel mid-division, then a fresh signed divide
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    t0 = cyc; start = 1'b0;
    repeat (10) @(posedge clk);
    #1 cancel = 1'b1;
    @(negedge clk); chk("busy_cancel", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    cancel = 1'b0; start = 1'b1; signed_div = 1'b1; a = 32'd100; b = 32'hFFFFFFF9;
    @(negedge clk); chk("busy_restart", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    e.q = 32'hFFFFFFF2; e.r = 32'd2; e.cyc = t0 + 45;
    sb.push_back(e);
    start = 1'b0;
    repeat (36) @(posedge clk);

    // back-to-back with start held: DIVU 9/4 then DIVU 15/4
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; a = 32'd9; b = 32'd4;
    @(posedge clk); #1;
    t0 = cyc;
    e.q = 32'd2; e.r = 32'd1; e.cyc = t0 + 33; sb.push_back(e);
    e.q = 32'd3; e.r = 32'd3; e.cyc = t0 + 35 + 33; sb.push_back(e);
    a = 32'd15;
    repeat (33) @(posedge clk);
    @(negedge clk); chk("b2b_done_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); chk("b2b_idle_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 start = 1'b0;
    repeat (35) @(posedge clk);

    // reset in the middle of a division
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; a = 32'd15; b = 32'd4;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_quot", quotient, '0);
    chk("midrst_rem", remainder, '0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(posedge clk);

    chk("scoreboard_empty", W'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the execute stage of the 5-stage MIPS pipeline.
- Serves DIV and DIVU. Consumes the forwarded execute-stage operands and produces quotient (LO) and remainder (HI).
- Raises busy so the hazard unit stalls F/D/E and bubbles M while a division is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- start  input  1  level request: the execute-stage instruction is a divide.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- a  input  WIDTH  dividend (forwarded srca).
- b  input  WIDTH  divisor (forwarded srcb).
- cancel  input  1  abort (flushE or exception); higher priority than start.
- busy  output  1  stall request to the hazard unit; combinational.
- valid  output  1  results valid; registered; high for exactly one cycle.
- quotient  output  WIDTH  registered quotient (LO).
- remainder  output  WIDTH  registered remainder (HI).

Behaviour:
- States: IDLE, BUSY, FIX, DONE. Encoding lives in the shared package.
- Reset (rst=0 at an edge): state=IDLE, cnt=0, valid=0, quotient=0, remainder=0, internal registers=0. Reset mid-operation discards the division.
- IDLE: if start=1 and cancel=0 at edge t0:
  - latch |a| and |b| (absolute values only when signed_div=1; otherwise raw);
  - latch the quotient sign (a[MSB]^b[MSB], signed only) and the remainder sign (a[MSB], signed only);
  - cnt=0; go to BUSY.
- BUSY: one quotient bit per edge, MSB first:
  - partial remainder shifts left and takes the next dividend bit;
  - subtract divisor; if no borrow, keep the difference and set q bit=1, else restore and set q bit=0;
  - subtraction is WIDTH+1 bits wide so the borrow is exact.
  - At the edge with cnt==WIDTH-1, go to FIX. That is edges t0+1 .. t0+WIDTH.
- FIX (edge t0+WIDTH+1):
  - negate the quotient if its sign flag is set; negate the remainder if its sign flag is set;
  - register both into quotient/remainder; valid<=1; go to DONE.
- DONE: one cycle only. valid=1, busy=0, so the pipeline advances on the next edge and captures the results.
  - Next edge: valid<=0, go to IDLE unconditionally.
  - start is ignored in DONE. A following divide (start still high next cycle) begins from IDLE.
- Latency: start sampled at t0 -> valid high between edges t0+33 and t0+34 (WIDTH=32).
- busy = (state==IDLE & start & ~cancel) | state==BUSY | state==FIX. busy is 0 in DONE and whenever cancel=1.
- quotient/remainder hold their last values until the next FIX or reset.
- Division by zero (b==0, either signedness):
  - quotient=all ones, remainder=a;
  - the FIX sign correction is bypassed;
  - full latency still applies.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0 (natural wrap; no trap).
- cancel=1 at any edge in BUSY or FIX: go to IDLE, valid stays 0, and the output registers are not updated.
- cancel in DONE: valid still drops next edge.
- cancel and start both high in IDLE: stay in IDLE.
- Operands a, b and signed_div are only sampled at the accept edge. Later changes are ignored.

Decomposition:
- Shared package holds:
  - the state encoding localparams (IDLE=2'd0, BUSY=2'd1, FIX=2'd2, DONE=2'd3);
  - DIV_LATENCY=WIDTH+1;
  - the ALU-control codes for DIV/DIVU that the decoder uses to drive start/signed_div.
- One sub-module is natural: div_step, a combinational single-iteration shift/subtract/select block, instantiated once inside the BUSY datapath.

Test Plan:
- DIVU 7/2: start at t0 -> busy high t0..t0+32, valid only in cycle t0+33; quotient=0x00000003, remainder=0x00000001.
- DIV -7/2 (a=0xFFFFFFF9, b=2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. DIVU of the same operands -> quotient=0, remainder=0x80000000.
- Divide by zero, a=0x12345678, b=0 (signed and unsigned) -> quotient=0xFFFFFFFF, remainder=0x12345678, valid at t0+33.
- Start DIVU 100/7, assert cancel at t0+10 -> no valid pulse, busy=0 from that cycle. New DIV 100/-7 started at t0+12 -> quotient=0xFFFFFFF2, remainder=2 at t0+45.
- Back-to-back: start held high through valid (DIVU 9/4 then DIVU 15/4) -> first valid gives 2,1; second accept is the edge after DONE and gives 3,3. Assert rst=0 mid-second-division -> valid=0, quotient=0, remainder=0, state IDLE.
